// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer controller and its counter.
package timer_pkg;

    localparam int TIMER_WIDTH  = 16;
    localparam int TIMER_PWIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_e;

    function automatic logic state_busy(input timer_state_e s);
        return (s == ST_RUN) || (s == ST_PAUSED);
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Clearable, enabled up-counter holding the timer's running count.
module timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/timer_ctrl.sv
// One-shot / periodic timer: command decode, terminal compare and period tally
// around a separate counter register.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH  = TIMER_WIDTH,
    parameter int PWIDTH = TIMER_PWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              mode,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [PWIDTH-1:0] periods,
    output logic              err
);

    timer_state_e     state;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;

    logic start_ok;
    logic run_step;
    logic at_limit;
    logic cnt_clr;
    logic cnt_en;

    // A start with a zero limit is a command that is refused, but it still
    // outranks pause, so the whole edge is a no-op apart from the err pulse.
    always_comb begin
        start_ok = 1'b0;
        run_step = 1'b0;
        at_limit = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        start_ok = !stop && start && (limit != '0);
        run_step = !stop && !start && (state == ST_RUN) && !pause;
        at_limit = (count == limit_q);
        cnt_en   = run_step && !at_limit;
        cnt_clr  = stop || start_ok || (run_step && at_limit && mode_q);
    end

    timer_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            limit_q <= '0;
            mode_q  <= 1'b0;
            periods <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (stop) begin
                state   <= ST_IDLE;
                periods <= '0;
                busy    <= 1'b0;
            end else if (start) begin
                if (limit != '0) begin
                    state   <= ST_RUN;
                    limit_q <= limit;
                    mode_q  <= mode;
                    periods <= '0;
                    busy    <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (pause) begin
                            state <= ST_PAUSED;
                        end else if (at_limit) begin
                            done <= 1'b1;
                            if (mode_q) begin
                                periods <= periods + PWIDTH'(1);
                            end else begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    // Leaving pause costs one edge; the count moves again on the next one.
                    ST_PAUSED: begin
                        if (!pause)
                            state <= ST_RUN;
                    end
                    default: begin
                        busy <= state_busy(state);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed and randomized check of timer_ctrl against a cycle-level behavioural model.
module tb_timer_ctrl;
    import timer_pkg::*;

    localparam int W  = TIMER_WIDTH;
    localparam int PW = TIMER_PWIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, pause, mode;
    logic [W-1:0]  limit;
    logic [W-1:0]  count;
    logic          busy, done, err;
    logic [PW-1:0] periods;

    timer_ctrl #(.WIDTH(W), .PWIDTH(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .mode    (mode),
        .limit   (limit),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .periods (periods),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a timer that is active (counting or frozen) or not,
    // with its latched terminal value and kind.
    int m_cnt, m_lim, m_per;
    bit m_active, m_frozen, m_periodic, m_done, m_err;
    logic prev_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_lim = 0; m_per = 0;
        m_active = 0; m_frozen = 0; m_periodic = 0;
        m_done = 0; m_err = 0;
        prev_done = 1'b0;
    endtask

    task automatic model_step();
        m_done = 0;
        m_err  = 0;
        if (stop) begin
            m_active = 0; m_frozen = 0; m_cnt = 0; m_per = 0;
        end else if (start) begin
            if (int'(limit) != 0) begin
                m_lim = int'(limit); m_periodic = mode;
                m_cnt = 0; m_per = 0; m_active = 1; m_frozen = 0;
            end else begin
                m_err = 1;
            end
        end else if (m_active) begin
            if (m_frozen) begin
                if (!pause) m_frozen = 0;
            end else if (pause) begin
                m_frozen = 1;
            end else if (m_cnt < m_lim) begin
                m_cnt = m_cnt + 1;
            end else begin
                m_done = 1;
                if (m_periodic) begin
                    m_cnt = 0;
                    m_per = (m_per + 1) % (1 << PW);
                end else begin
                    m_active = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
        chk("count",   32'(count),   32'(m_cnt));
        chk("busy",    32'(busy),    32'(m_active));
        chk("done",    32'(done),    32'(m_done));
        chk("err",     32'(err),     32'(m_err));
        chk("periods", 32'(periods), 32'(m_per));
        chk("count_le_limit", 32'(int'(count) <= m_lim), 32'd1);
        chk("done_width", 32'(prev_done && done), 32'd0);
        prev_done = done;
    endtask

    task automatic step(input bit st, input bit sp, input bit ps, input bit md, input int lim);
        start = st; stop = sp; pause = ps; mode = md; limit = W'(lim);
        tick();
    endtask

    // Called just after a checked edge: drop reset between edges and release it
    // well before the next rising edge.
    task automatic async_reset(input string tag);
        start = 0; stop = 0; pause = 0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk({tag, "_count"},   32'(count),   32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_periods"}, 32'(periods), 32'd0);
        #1 rst = 1'b1;
    endtask

    initial begin
        int hold_cnt;
        bit seen;
        rst = 1'b0; start = 0; stop = 0; pause = 0; mode = 0; limit = '0;
        model_reset();
        #2;
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_periods", 32'(periods), 32'd0);
        #10 rst = 1'b1;

        // One-shot, limit 5
        step(1, 0, 0, 0, 5);
        chk("os_start_count", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 5);
        chk("os_count5", 32'(count), 32'd5);
        step(0, 0, 0, 0, 5);
        chk("os_done",  32'(done),  32'd1);
        chk("os_hold",  32'(count), 32'd5);
        chk("os_idle",  32'(busy),  32'd0);
        step(0, 0, 0, 0, 5);
        chk("os_done_drop", 32'(done),  32'd0);
        chk("os_hold2",     32'(count), 32'd5);

        // Periodic, limit 3; limit input changes mid-run are ignored
        step(1, 0, 0, 1, 3);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 9);
        chk("per_periods", 32'(periods), 32'd3);
        chk("per_done",    32'(done),    32'd1);
        chk("per_wrap",    32'(count),   32'd0);

        // Pause at count 4 of a limit-10 one-shot
        step(1, 0, 0, 0, 10);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 10);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 10);
            chk("pause_hold", 32'(count), 32'd4);
            chk("pause_busy", 32'(busy),  32'd1);
        end
        seen = 0;
        hold_cnt = 0;
        while (!seen && hold_cnt < 30) begin
            step(0, 0, 0, 0, 10);
            seen = done;
            hold_cnt++;
        end
        chk("pause_done_seen", 32'(seen), 32'd1);

        // Rejected start and start+stop collision
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("zero_err",   32'(err),   32'd1);
        chk("zero_busy",  32'(busy),  32'd0);
        chk("zero_count", 32'(count), 32'd0);
        step(0, 0, 0, 0, 0);
        chk("zero_err_drop", 32'(err), 32'd0);
        step(1, 0, 0, 0, 9);
        step(0, 0, 0, 0, 9);
        step(1, 1, 0, 0, 7);
        chk("ss_count", 32'(count), 32'd0);
        chk("ss_busy",  32'(busy),  32'd0);

        // Async reset at count 7
        step(1, 0, 0, 0, 20);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 20);
        chk("ar_count7", 32'(count), 32'd7);
        async_reset("ar");
        step(0, 0, 0, 0, 20);
        chk("ar_no_done", 32'(done), 32'd0);
        step(1, 0, 0, 0, 2);
        chk("ar_restart_busy", 32'(busy), 32'd1);

        // Randomized commands
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 14) == 0,
                     $urandom_range(0, 49) == 0,
                     $urandom_range(0, 4) == 0,
                     1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 12)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
